coin_pulse_conditioner: RTL and testbench

- Front-end stage that sits directly upstream of the vending-machine FSM. It turns the raw, bouncy coin-sensor line into the clean single-cycle `x` pulse the FSM counts.
- Processing chain: synchronise, debounce, measure the width of each debounced high pulse, then classify the pulse as valid coin, reject, or jam.
- Holdoff window after each coin suppresses double counting. Every accepted coin produces exactly one `x` pulse.

---
 rtl/coin_pulse_conditioner.sv | 142 ++++++++++++++
 tb/tb_coin_pulse_conditioner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/coin_pulse_conditioner.sv
// Coin sensor front end: synchronise, debounce, measure and classify
// each coin pulse into a single clean x, a reject pulse or a jam level.
module coin_pulse_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int MIN_PULSE       = 20,
    parameter int MAX_PULSE       = 200,
    parameter int HOLDOFF         = 16,
    parameter int CNT_W           = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic coin_raw,
    input  logic enable,
    output logic x,
    output logic coin_reject,
    output logic jam,
    output logic busy
);

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_N = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] MINP  = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] MAXP  = CNT_W'(MAX_PULSE);
    localparam logic [CNT_W-1:0] HOLDP = CNT_W'(HOLDOFF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_HOLDOFF,
        S_JAM
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   deb;
    logic [CNT_W-1:0]       deb_cnt;

    state_t           state, state_d;
    logic [CNT_W-1:0] width, width_d;
    logic [CNT_W-1:0] hcnt, hcnt_d;
    logic             en_q, en_d;
    logic             x_d, rej_d, jam_d, busy_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q  <= '0;
            deb     <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], coin_raw};
            if (s == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt + ONE == DEB_N) begin
                deb     <= ~deb;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + ONE;
            end
        end
    end

    always_comb begin
        state_d = state;
        width_d = width;
        hcnt_d  = hcnt;
        en_d    = en_q;
        x_d     = 1'b0;
        rej_d   = 1'b0;
        jam_d   = 1'b0;
        case (state)
            S_IDLE: begin
                if (deb) begin
                    state_d = S_MEASURE;
                    width_d = ONE;
                    en_d    = enable;
                end
            end
            S_MEASURE: begin
                if (deb) begin
                    // width saturates one past the limit so held lines never wrap
                    if (width >= MAXP) begin
                        state_d = S_JAM;
                        jam_d   = 1'b1;
                        width_d = MAXP + ONE;
                    end else begin
                        width_d = width + ONE;
                    end
                end else begin
                    if (en_q && width >= MINP && width <= MAXP)
                        x_d = 1'b1;
                    else
                        rej_d = 1'b1;
                    state_d = S_HOLDOFF;
                    hcnt_d  = '0;
                end
            end
            S_JAM: begin
                if (deb) begin
                    jam_d = 1'b1;
                end else begin
                    rej_d   = 1'b1;
                    state_d = S_HOLDOFF;
                    hcnt_d  = '0;
                end
            end
            S_HOLDOFF: begin
                if (hcnt < HOLDP)
                    hcnt_d = hcnt + ONE;
                if (hcnt >= HOLDP && !deb)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_IDLE;
            width       <= '0;
            hcnt        <= '0;
            en_q        <= 1'b0;
            x           <= 1'b0;
            coin_reject <= 1'b0;
            jam         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            width       <= width_d;
            hcnt        <= hcnt_d;
            en_q        <= en_d;
            x           <= x_d;
            coin_reject <= rej_d;
            jam         <= jam_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// Bench for coin_pulse_conditioner: expected pulses are queued with
// their exact cycle and matched by an independent output monitor.
module tb_coin_pulse_conditioner;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic coin_raw = 1'b0;
    logic enable = 1'b1;
    logic x, coin_reject, jam, busy;

    typedef struct {
        bit is_x;
        int cyc;
    } exp_t;

    exp_t q[$];
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int xcount = 0;

    coin_pulse_conditioner dut (
        .clock(clock),
        .reset(reset),
        .coin_raw(coin_raw),
        .enable(enable),
        .x(x),
        .coin_reject(coin_reject),
        .jam(jam),
        .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: every x / coin_reject sample must match the queue head.
    always @(negedge clock) begin
        if (x || coin_reject) begin
            exp_t e;
            if (x) xcount++;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: x=%0b rej=%0b at cycle %0d, none expected",
                         x, coin_reject, cyc);
            end else begin
                e = q.pop_front();
                if ((x && coin_reject) || (x != e.is_x) || (coin_reject == e.is_x)
                    || (cyc != e.cyc)) begin
                    failures++;
                    $display("FAIL pulse_match: got x=%0b rej=%0b at cycle %0d, expected %s at cycle %0d",
                             x, coin_reject, cyc, e.is_x ? "x" : "reject", e.cyc);
                end
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    // Raw high for n cycles; deb follows 10 cycles later, result 1 cycle after deb falls.
    task automatic coin(input int n, input bit is_x, output int c);
        @(negedge clock);
        c = cyc;
        q.push_back('{is_x, c + n + 11});
        coin_raw = 1'b1;
        repeat (n) @(negedge clock);
        coin_raw = 1'b0;
    endtask

    initial begin
        int c;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_x", x, 1'b0);
        chk("reset_rej", coin_reject, 1'b0);
        chk("reset_jam", jam, 1'b0);
        chk("reset_busy", busy, 1'b0);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        // Four clean coins
        for (int i = 0; i < 4; i++) begin
            coin(50, 1'b1, c);
            repeat (40) @(negedge clock);
        end
        checks++;
        if (xcount != 4) begin
            failures++;
            $display("FAIL clean_count: got %0d x pulses expected 4", xcount);
        end

        // Bounce: short bursts never reach the debounced level
        for (int i = 0; i < 3; i++) begin
            coin_raw = 1'b1;
            repeat (5) begin
                @(negedge clock);
                chk("glitch_busy", busy, 1'b0);
            end
            coin_raw = 1'b0;
            repeat (3) begin
                @(negedge clock);
                chk("glitch_busy", busy, 1'b0);
            end
        end
        repeat (20) begin
            @(negedge clock);
            chk("glitch_busy", busy, 1'b0);
        end

        // Short coin, then holdoff boundary
        coin(12, 1'b0, c);
        wait_until(c + 23 + 16);
        chk("short_holdoff_busy", busy, 1'b1);
        wait_until(c + 23 + 17);
        chk("short_idle_busy", busy, 1'b0);
        repeat (20) @(negedge clock);

        // Jam, with a second pulse starting inside holdoff
        @(negedge clock);
        c = cyc;
        q.push_back('{1'b0, c + 311});
        coin_raw = 1'b1;
        wait_until(c + 210);
        chk("jam_before_limit", jam, 1'b0);
        wait_until(c + 211);
        chk("jam_at_limit", jam, 1'b1);
        wait_until(c + 300);
        chk("jam_held", jam, 1'b1);
        coin_raw = 1'b0;
        wait_until(c + 310);
        chk("jam_until_deb_fall", jam, 1'b1);
        wait_until(c + 311);
        chk("jam_cleared", jam, 1'b0);
        wait_until(c + 312);
        coin_raw = 1'b1;
        wait_until(c + 362);
        coin_raw = 1'b0;
        wait_until(c + 372);
        chk("holdoff_wait_deb", busy, 1'b1);
        wait_until(c + 373);
        chk("holdoff_released", busy, 1'b0);
        repeat (20) @(negedge clock);

        // Disabled at the rising edge, enabled mid-pulse
        enable = 1'b0;
        @(negedge clock);
        c = cyc;
        q.push_back('{1'b0, c + 61});
        coin_raw = 1'b1;
        wait_until(c + 15);
        enable = 1'b1;
        wait_until(c + 50);
        coin_raw = 1'b0;
        repeat (40) @(negedge clock);

        // Reset mid-measure; remaining high is a new 29-cycle pulse
        @(negedge clock);
        c = cyc;
        q.push_back('{1'b1, c + 61});
        coin_raw = 1'b1;
        wait_until(c + 20);
        chk("pre_reset_busy", busy, 1'b1);
        reset = 1'b0;
        wait_until(c + 21);
        reset = 1'b1;
        chk("midreset_x", x, 1'b0);
        chk("midreset_rej", coin_reject, 1'b0);
        chk("midreset_jam", jam, 1'b0);
        chk("midreset_busy", busy, 1'b0);
        wait_until(c + 50);
        coin_raw = 1'b0;
        repeat (40) @(negedge clock);

        // Reset mid-measure, raw released before debounce completes
        @(negedge clock);
        c = cyc;
        coin_raw = 1'b1;
        wait_until(c + 20);
        reset = 1'b0;
        wait_until(c + 21);
        reset = 1'b1;
        wait_until(c + 25);
        coin_raw = 1'b0;
        repeat (30) begin
            @(negedge clock);
            chk("short_after_reset_busy", busy, 1'b0);
        end

        repeat (20) @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending_events: %0d expected pulses never seen, first due cycle %0d",
                     q.size(), q[0].cyc);
        end
        checks++;
        if (xcount != 5) begin
            failures++;
            $display("FAIL total_x: got %0d expected 5", xcount);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
